daq_drain_arbiter: RTL
======================

# daq_drain_arbiter

Round-robin scheduler that shares the single downstream USB slave-FIFO write port among NREQ daqpacketizer output FIFOs. Transfers whole packets only, prefixing each with a source tag word, so the host can demultiplex boards/channels. Sits between the packetizer output FIFOs (read side) and the USB interface write FIFO, in the packetizer's read-clock domain.

## Interface
- NREQ, 4, number of requesting packet FIFOs (2..8)
- PKT_WORDS, 16, 16-bit words per packet (2..255)
- TAG_HI, 8'hA5, upper byte of tag word
- clk_i  in  1  system clock (same clock as packetizer FIFO read ports and USB write port)
- reset_i  in  1  synchronous, active-high reset
- en_i  in  1  allow new grants; does not abort a packet in progress
- pkt_avail_i  in  NREQ  bit n: FIFO n holds at least one complete packet
- fifo_db_i  in  16*NREQ  FIFO read data, requester n on bits [16n+15:16n]; non-show-ahead, valid cycle after rdreq
- fifo_rdreq_o  out  NREQ  read request, one-hot or zero
- usb_full_i  in  1  downstream almost-full; asserted while fewer than 3 free slots remain
- usb_wr_o  out  1  downstream write strobe, registered
- usb_db_o  out  16  downstream write data, registered
- busy_o  out  1  high from grant through end of drain
- pkt_cnt_o  out  16  packets fully forwarded, wraps 0xFFFF->0x0000

## Operation
- States: IDLE, XFER, DRAIN.
- Reset: state IDLE, rr pointer 0, fifo_rdreq_o 0, usb_wr_o 0, usb_db_o 0, busy_o 0, pkt_cnt_o 0, word/in-flight counters 0. Reset mid-packet abandons it; no tag-completion, pkt_cnt_o unchanged from 0.
- IDLE: grant when en_i=1, usb_full_i=0, pkt_avail_i!=0. Winner = first set bit of pkt_avail_i searching from rr pointer upward, wrapping at NREQ-1->0. On grant: register g, usb_wr_o<=1, usb_db_o<={TAG_HI, 4'h0, g[3:0]}, remaining<=PKT_WORDS, go XFER.
- XFER: fifo_rdreq_o[g] = (remaining!=0) & !usb_full_i (combinational from registered state and usb_full_i). Each asserted rdreq decrements remaining. When the last rdreq issues, go DRAIN.
- Data path: fifo_db_i slice g captured in cycle after each rdreq; registered to usb_db_o with usb_wr_o=1 the following cycle. In-flight words (max 2) are always written regardless of usb_full_i; headroom guaranteed by the 3-slot almost-full contract.
- DRAIN: wait until no word in flight; then pkt_cnt_o++, rr pointer <= (g+1) mod NREQ, go IDLE.
- usb_wr_o=0 in every cycle not carrying a tag or data word.
- en_i falling during XFER/DRAIN: packet completes normally; no further grant.
- pkt_avail_i for the granted FIFO dropping mid-packet: ignored (contract: packetizer only raises it for complete packets).

## Timing
- Grant decided in cycle 0 (IDLE). Tag on usb in cycle 1. Without stalls: rdreq word k in cycle 1+k, data word k on usb in cycle 3+k, k=0..PKT_WORDS-1.
- Last data word on usb cycle PKT_WORDS+2; DRAIN exits end of that cycle; next grant earliest cycle PKT_WORDS+3. PKT_WORDS=16: tag cycle 1, gap cycle 2, data cycles 3..18, pkt_cnt_o increments visible cycle 19.
- busy_o high cycles 1..PKT_WORDS+2.
- usb_full_i stall of S cycles during XFER delays all subsequent words by S; no word lost or duplicated.
- usb_full_i high in IDLE blocks grant; en_i/pkt_avail_i sampled only in IDLE.

## Test plan
- Single requester: NREQ=4, PKT_WORDS=16, pkt_avail_i=4'b0100, FIFO 2 data 0x0200..0x020F -> usb sequence 0xA502, 0x0200..0x020F, tag cycle 1, data cycles 3..18, pkt_cnt_o=1 at cycle 19, fifo_rdreq_o only bit 2.
- Round-robin fairness: pkt_avail_i=4'b1111 held -> tags in order A500, A501, A502, A503, A500; after pointer at 2 with avail=4'b0011 -> next tag A500.
- Back-pressure: usb_full_i high 5 cycles after word 4's rdreq -> rdreq gaps 5 cycles, usb receives all 16 words in order, exactly 17 writes, ≤2 writes while full.
- en_i drop mid-packet: deassert at cycle 6 -> packet completes (17 writes), no tag afterwards while pkt_avail_i!=0.
- Reset mid-packet at cycle 8 -> next cycle all outputs 0, pkt_cnt_o=0; after release with avail=4'b0010 -> tag 0xA501.
- Counter wrap: preload by running 65536 packets (or force) -> pkt_cnt_o 0xFFFF->0x0000.

Source files
------------

// File: rtl/daq_drain_arbiter.sv
// daq_drain_arbiter
//   Round-robin drain of NREQ packetizer output FIFOs into one USB slave-FIFO
//   write port. Whole packets only; each packet is preceded by a tag word
//   {TAG_HI, 4'h0, source index} so the host can demultiplex sources.
//
// Ports
//   clk_i         system clock (FIFO read side and USB write side)
//   reset_i       synchronous, active-high reset
//   en_i          allow new grants; a packet in progress always completes
//   pkt_avail_i   bit n: FIFO n holds at least one complete packet
//   fifo_db_i     FIFO read data, requester n on [16n+15:16n], valid the
//                 cycle after its rdreq (non-show-ahead)
//   fifo_rdreq_o  read request, one-hot or zero
//   usb_full_i    downstream almost-full (fewer than 3 free slots)
//   usb_wr_o      registered downstream write strobe
//   usb_db_o      registered downstream write data
//   busy_o        high from grant until the packet has fully drained
//   pkt_cnt_o     count of fully forwarded packets, wraps at 16 bits
module daq_drain_arbiter #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned PKT_WORDS = 16,
  parameter logic [7:0]  TAG_HI    = 8'hA5
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                en_i,
  input  logic [NREQ-1:0]     pkt_avail_i,
  input  logic [16*NREQ-1:0]  fifo_db_i,
  output logic [NREQ-1:0]     fifo_rdreq_o,
  input  logic                usb_full_i,
  output logic                usb_wr_o,
  output logic [15:0]         usb_db_o,
  output logic                busy_o,
  output logic [15:0]         pkt_cnt_o
);

  localparam int unsigned GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   rr_q, rr_d;
  logic [GW-1:0]   g_q, g_d;
  logic [7:0]      rem_q, rem_d;
  logic            infl_q, infl_d;
  logic            wr_q, wr_d;
  logic [15:0]     db_q, db_d;
  logic [15:0]     cnt_q, cnt_d;

  logic            win_found;
  logic [GW-1:0]   win;
  int unsigned     idx;
  logic            rd_en;

  // First requester at or above the round-robin pointer, wrapping to 0.
  always_comb begin
    win_found = 1'b0;
    win       = rr_q;
    idx       = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = 32'(rr_q) + i;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end
      if (!win_found && pkt_avail_i[idx]) begin
        win_found = 1'b1;
        win       = GW'(idx);
      end
    end
  end

  assign rd_en = (state_q == XFER) && (rem_q != 8'd0) && !usb_full_i;

  always_comb begin
    fifo_rdreq_o = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      fifo_rdreq_o[i] = rd_en && (g_q == GW'(i));
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    g_d     = g_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    wr_d    = 1'b0;
    db_d    = db_q;
    infl_d  = rd_en;

    case (state_q)
      IDLE: begin
        if (en_i && !usb_full_i && win_found) begin
          g_d     = win;
          wr_d    = 1'b1;
          db_d    = {TAG_HI, 4'h0, 4'(win)};
          rem_d   = 8'(PKT_WORDS);
          state_d = XFER;
        end
      end
      XFER: begin
        if (rd_en) begin
          rem_d = rem_q - 8'd1;
          if (rem_q == 8'd1) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Completion waits for the last requested word to leave the
        // capture stage; it is written to usb on this same edge.
        if (!infl_q) begin
          cnt_d   = cnt_q + 16'd1;
          rr_d    = (g_q == GW'(NREQ - 1)) ? '0 : g_q + GW'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Words already requested are always forwarded; the almost-full
    // threshold leaves room for them.
    if (infl_q) begin
      wr_d = 1'b1;
      db_d = fifo_db_i[{g_q, 4'b0000} +: 16];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      rr_q    <= '0;
      g_q     <= '0;
      rem_q   <= '0;
      infl_q  <= 1'b0;
      wr_q    <= 1'b0;
      db_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      g_q     <= g_d;
      rem_q   <= rem_d;
      infl_q  <= infl_d;
      wr_q    <= wr_d;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

  assign usb_wr_o  = wr_q;
  assign usb_db_o  = db_q;
  assign busy_o    = (state_q != IDLE);
  assign pkt_cnt_o = cnt_q;

endmodule
